// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_CLKS_PER_BIT = 104;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side byte write bus of the transmitter: write strobe/data plus FIFO status.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                        wr_en;
    logic [7:0]                  wr_data;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        overflow;
    logic                        overflow_clr;

    modport master (
        output wr_en, wr_data, overflow_clr,
        input  full, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, overflow_clr,
        output full, level, overflow
    );
endinterface

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with registered status flags and head read data available combinationally.
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wd,
    output logic [7:0]             rd,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests against the pre-edge flags and compute the next occupancy.
    always_comb begin
        do_push_s   = push && !full_r;
        do_pop_s    = pop && !empty_r;
        level_nxt_s = level_r;
        case ({do_push_s, do_pop_s})
            2'b10:   level_nxt_s = level_r + 1'b1;
            2'b01:   level_nxt_s = level_r - 1'b1;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers and status; pointer width makes them wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == FULL_LVL);
            empty_r <= (level_nxt_s == {LW{1'b0}});
        end
    end

    // Storage array, no reset needed since empty pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wd;
        end
    end

    assign rd    = mem_r[rptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = level_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame serializer with sticky overflow flag.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_buffered_if.slave   bus,
    output logic                busy,
    output logic                tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                   state_r;
    logic [BW-1:0]               baud_r;
    logic [2:0]                  bit_r;
    logic [7:0]                  shreg_r;
    logic                        tx_r;
    logic                        busy_r;
    logic                        ovf_r;
    logic                        bit_end_s;
    logic                        pop_s;
    logic [7:0]                  fifo_rd_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_s;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.wr_en),
        .pop     (pop_s),
        .wd      (bus.wr_data),
        .rd      (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // A pop happens when idle, or at the end of a stop bit so frames run back to back.
    always_comb begin
        bit_end_s = (baud_r == BAUD_LAST);
        case (state_r)
            IDLE:    pop_s = !fifo_empty_s;
            STOP:    pop_s = bit_end_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Sticky overflow: a dropped write outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= 1'b0;
        end else if (bus.wr_en && fifo_full_s) begin
            ovf_r <= 1'b1;
        end else if (bus.overflow_clr) begin
            ovf_r <= 1'b0;
        end
    end

    // Frame FSM with baud counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shreg_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (!fifo_empty_s) begin
                        shreg_r <= fifo_rd_s;
                        tx_r    <= 1'b0;
                        bit_r   <= 3'd0;
                        baud_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_r  <= '0;
                        tx_r    <= shreg_r[0];
                        state_r <= DATA;
                    end else begin
                        baud_r <= baud_r + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_r <= '0;
                        if (bit_r == BIT_LAST) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            shreg_r <= {1'b0, shreg_r[7:1]};
                            tx_r    <= shreg_r[1];
                            bit_r   <= bit_r + 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_r <= '0;
                        if (!fifo_empty_s) begin
                            shreg_r <= fifo_rd_s;
                            tx_r    <= 1'b0;
                            bit_r   <= 3'd0;
                            state_r <= START;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + 1'b1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.full     = fifo_full_s;
    assign bus.level    = fifo_level_s;
    assign bus.overflow = ovf_r;
    assign busy         = busy_r;
    assign tx           = tx_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized scoreboard bench for uart_tx_buffered: frame-level reference model plus serial-line monitor.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    logic tx;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents, frame-in-progress countdown, expected byte stream.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    bit         m_busy;
    int         m_rem;
    logic [7:0] m_cur;
    bit         m_ovf;
    int         m_frames;
    int         dropped;

    int cyc, peak_level, busy_count, first_busy, last_busy;
    bit full_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int p;
        if (!m_busy) return 1'b1;
        p = FRAME - m_rem;
        if (p < CPB) return 1'b0;
        if (p >= 9 * CPB) return 1'b1;
        return m_cur[(p - CPB) / CPB];
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_busy = 1'b0;
        m_rem  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d, input logic clr);
        int  pre_size;
        bit  pop;
        pre_size = mq.size();
        pop = 1'b0;
        if (m_busy) begin
            if (m_rem == 1) begin
                if (pre_size > 0) pop = 1'b1;
                else m_busy = 1'b0;
            end else begin
                m_rem--;
            end
        end else if (pre_size > 0) begin
            pop = 1'b1;
        end
        if (pop) begin
            m_cur  = mq.pop_front();
            m_busy = 1'b1;
            m_rem  = FRAME;
            m_frames++;
        end
        if (w && pre_size == DEPTH) begin
            m_ovf = 1'b1;
            dropped++;
        end else begin
            if (w) begin
                mq.push_back(d);
                exp_q.push_back(d);
            end
            if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic cycle(input logic w, input logic [7:0] d, input logic clr);
        bus.wr_en        = w;
        bus.wr_data      = d;
        bus.overflow_clr = clr;
        @(posedge clk);
        model_edge(w, d, clr);
        #1;
        check("level", 32'(bus.level), 32'(mq.size()));
        check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'(m_busy));
        check("tx", 32'(tx), 32'(model_tx()));
        cyc++;
        if (int'(bus.level) > peak_level) peak_level = int'(bus.level);
        if (bus.full) full_seen = 1'b1;
        if (busy) begin
            busy_count++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
        end
        bus.wr_en        = 1'b0;
        bus.overflow_clr = 1'b0;
    endtask

    task automatic clear_stats();
        peak_level = 0;
        busy_count = 0;
        first_busy = -1;
        last_busy  = -1;
        full_seen  = 1'b0;
        dropped    = 0;
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while ((m_busy || mq.size() != 0) && k < max_cycles) begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("drain_done", 32'(m_busy || mq.size() != 0), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check("stream_consumed", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_stop_end(input int max_cycles);
        int k = 0;
        while (!(m_busy && m_rem == 1) && k < max_cycles) begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("reached_stop_end", 32'(m_busy && m_rem == 1), 32'd1);
    endtask

    // Serial-line monitor: captures one frame of samples after each start edge and scores it.
    bit          in_frame = 1'b0;
    int          mon_n;
    logic [39:0] smp;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                smp[0]   = 1'b0;
                mon_n    = 1;
            end
        end else begin
            smp[mon_n] = tx;
            mon_n++;
            if (mon_n == FRAME) begin
                logic       stable;
                logic [7:0] rx;
                in_frame = 1'b0;
                stable   = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int s = 0; s < CPB; s++)
                        if (smp[b*CPB+s] !== smp[b*CPB]) stable = 1'b0;
                for (int i = 0; i < 8; i++) rx[i] = smp[(i+1)*CPB + CPB/2];
                check("bit_period_stable", 32'(stable), 32'd1);
                check("stop_bit", 32'(smp[9*CPB]), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte %0h expected none", rx);
                end else begin
                    check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int f0, k;
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.overflow_clr = 1'b0;
        m_frames = 0;
        cyc      = 0;
        model_reset();
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Single byte 0xA5
        clear_stats();
        cycle(1'b1, 8'hA5, 1'b0);
        drain(200);
        check("a5_busy_cycles", 32'(busy_count), 32'd40);

        // Three back-to-back bytes
        clear_stats();
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'h55, 1'b0);
        drain(400);
        check("b2b_peak_level", 32'(peak_level), 32'd2);
        check("b2b_busy_cycles", 32'(busy_count), 32'd120);
        check("b2b_busy_span", 32'(last_busy - first_busy + 1), 32'd120);

        // 18 writes while busy: two drop
        clear_stats();
        cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom), 1'b0);
        check("ovf_full_seen", 32'(full_seen), 32'd1);
        check("ovf_dropped", 32'(dropped), 32'd2);
        check("ovf_flag_set", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("ovf_flag_cleared", 32'(bus.overflow), 32'd0);
        drain(1000);

        // Write at DEPTH-1 coinciding with a stop-end pop
        clear_stats();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0);
        check("d1_level_before", 32'(bus.level), 32'(DEPTH - 1));
        wait_stop_end(100);
        cycle(1'b1, 8'($urandom), 1'b0);
        check("d1_level_after", 32'(bus.level), 32'(DEPTH - 1));
        check("d1_no_overflow", 32'(bus.overflow), 32'd0);
        drain(1000);

        // Write 0x3C exactly as the last stop bit ends on an empty FIFO
        cycle(1'b1, 8'($urandom), 1'b0);
        wait_stop_end(100);
        cycle(1'b1, 8'h3C, 1'b0);
        check("gap_busy_low", 32'(busy), 32'd0);
        check("gap_tx_high", 32'(tx), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        check("gap_start_bit", 32'(tx), 32'd0);
        check("gap_busy_high", 32'(busy), 32'd1);
        drain(200);

        // Random traffic with occasional overflow clears
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 31) == 0));
        drain(2000);

        // Asynchronous reset during the second of three queued frames
        f0 = m_frames;
        cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'($urandom), 1'b0);
        k = 0;
        while (!(m_frames == f0 + 2 && (FRAME - m_rem) >= 3 * CPB) && k < 200) begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("rst_reached_data", 32'(m_frames == f0 + 2), 32'd1);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_level", 32'(bus.level), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) cycle(1'b0, 8'h00, 1'b0);
        check("post_rst_tx", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
